// File: rtl/arm_bus_pkg.sv
// Shared constants, state types and the CRC-16-CCITT byte step for the arm motor bus receiver.
package arm_bus_pkg;

    localparam logic [7:0]  ARM_BUS_SOF       = 8'hAA;
    localparam int          ARM_BUS_FRAME_LEN = 11;
    localparam logic [15:0] CRC16_POLY        = 16'h1021;
    localparam logic [15:0] CRC16_INIT        = 16'hFFFF;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    typedef enum logic [1:0] {
        F_HUNT  = 2'd0,
        F_BODY  = 2'd1,
        F_CHECK = 2'd2
    } frame_state_t;

    // MSB-first, non-reflected update; eight shift/xor steps unrolled by synthesis.
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
        logic [15:0] c;
        c = crc ^ {data, 8'h00};
        for (int i = 0; i < 8; i++) begin
            if (c[15]) c = {c[14:0], 1'b0} ^ CRC16_POLY;
            else       c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

endpackage

// File: rtl/arm_bus_status_rx_if.sv
// Status bus from the arm bus receiver to the motor register bank, plus FSM debug visibility.
interface arm_bus_status_rx_if;
    import arm_bus_pkg::*;

    // status_valid is a one-cycle strobe with no backpressure: the sink must take the
    // fields while it is high; the fields also hold until the next good frame.
    logic         status_valid;
    logic [7:0]   status_motor;
    logic [15:0]  encoder0_position;
    logic [15:0]  encoder1_position;
    logic [15:0]  current;
    logic [7:0]   error_code;
    logic [31:0]  good_frames;
    logic [31:0]  crc_errors;
    logic [31:0]  framing_errors;
    frame_state_t frame_state;
    rx_state_t    rx_state;
    logic         rx_busy;

    modport master (
        output status_valid, status_motor, encoder0_position, encoder1_position,
               current, error_code, good_frames, crc_errors, framing_errors,
               frame_state, rx_state, rx_busy
    );

    modport slave (
        input status_valid, status_motor, encoder0_position, encoder1_position,
              current, error_code, good_frames, crc_errors, framing_errors,
              frame_state, rx_state, rx_busy
    );

endinterface

// File: rtl/arm_bus_uart_rx.sv
// 8N1 UART byte receiver with a 2-FF input synchronizer; samples mid-bit at the latched bit period.
module arm_bus_uart_rx
    import arm_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        rx_i,
    input  logic [15:0] clks_per_bit,
    output logic        byte_valid,
    output logic        byte_err,
    output logic [7:0]  data,
    output logic        busy,
    output logic [15:0] cpb,
    output rx_state_t   state
);

    logic        sync_q1;
    logic        sync_q2;
    logic        rx_prev;
    rx_state_t   state_q;
    rx_state_t   state_d;
    logic [15:0] cnt_q;
    logic [2:0]  bit_q;
    logic [7:0]  shift_q;
    logic [15:0] cpb_q;
    logic        fall;
    logic        tick;
    logic [15:0] cpb_sel;

    assign fall    = rx_prev & ~sync_q2;
    assign cpb_sel = (clks_per_bit < 16'd4) ? 16'd4 : clks_per_bit;
    // The start bit is checked half a period in, so later samples land mid-bit.
    assign tick    = (state_q == RX_START) ? (cnt_q == (cpb_q >> 1) - 16'd1)
                                           : (cnt_q == cpb_q - 16'd1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= RX_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            RX_IDLE:  if (fall) state_d = RX_START;
            RX_START: if (tick) state_d = sync_q2 ? RX_IDLE : RX_DATA;
            RX_DATA:  if (tick && bit_q == 3'd7) state_d = RX_STOP;
            RX_STOP:  if (tick) state_d = RX_IDLE;
            default:  state_d = RX_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q1    <= 1'b1;
            sync_q2    <= 1'b1;
            rx_prev    <= 1'b1;
            cnt_q      <= '0;
            bit_q      <= '0;
            shift_q    <= '0;
            cpb_q      <= 16'd4;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
        end else begin
            sync_q1    <= rx_i;
            sync_q2    <= sync_q1;
            rx_prev    <= sync_q2;
            byte_valid <= 1'b0;
            byte_err   <= 1'b0;
            if (state_q == RX_IDLE) begin
                cnt_q <= '0;
                bit_q <= '0;
                if (fall) cpb_q <= cpb_sel;
            end else begin
                cnt_q <= tick ? 16'd0 : cnt_q + 16'd1;
            end
            if (state_q == RX_DATA && tick) begin
                shift_q <= {sync_q2, shift_q[7:1]};
                bit_q   <= bit_q + 3'd1;
            end
            if (state_q == RX_STOP && tick) begin
                byte_valid <= sync_q2;
                byte_err   <= ~sync_q2;
            end
        end
    end

    assign data  = shift_q;
    assign busy  = (state_q != RX_IDLE);
    assign cpb   = cpb_q;
    assign state = state_q;

endmodule

// File: rtl/arm_bus_status_rx.sv
// Arm motor bus status receiver: frames UART bytes, checks CRC-16, strobes per-motor status.
// Frame quality counters exist only when ARM_BUS_RX_STATS_EN is defined; otherwise they read 0.
module arm_bus_status_rx
    import arm_bus_pkg::*;
#(
    parameter int NUMBER_OF_MOTORS = 10,
    parameter int ID_BASE          = 128,
    parameter int TIMEOUT_BITS     = 20
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_i,
    input  logic [15:0]         clks_per_bit,
    arm_bus_status_rx_if.master bus
);

    logic         byte_valid;
    logic         byte_err;
    logic [7:0]   rx_byte;
    logic         rx_busy;
    logic [15:0]  cpb;
    rx_state_t    rx_state;

    arm_bus_uart_rx u_uart (
        .clk          (clk),
        .reset        (reset),
        .rx_i         (rx_i),
        .clks_per_bit (clks_per_bit),
        .byte_valid   (byte_valid),
        .byte_err     (byte_err),
        .data         (rx_byte),
        .busy         (rx_busy),
        .cpb          (cpb),
        .state        (rx_state)
    );

    frame_state_t fstate_q;
    frame_state_t fstate_d;
    logic [3:0]   idx_q;
    logic [15:0]  crc_q;
    logic [15:0]  rx_crc_q;
    logic [7:0]   id_q;
    logic [15:0]  enc0_q;
    logic [15:0]  enc1_q;
    logic [15:0]  cur_q;
    logic [7:0]   err_q;
    logic [31:0]  tmo_q;
    logic [31:0]  tmo_limit;
    logic         tmo_expired;
    logic [8:0]   slot_wide;
    logic         in_range;
    logic         crc_ok;
    logic         last_byte;
    logic         good_ev;
    logic         crc_ev;
    logic         frm_ev;

    logic         valid_q;
    logic [7:0]   motor_q;
    logic [15:0]  enc0_out_q;
    logic [15:0]  enc1_out_q;
    logic [15:0]  cur_out_q;
    logic [7:0]   err_out_q;

    assign tmo_limit   = 32'(TIMEOUT_BITS) * {16'd0, cpb};
    assign tmo_expired = (tmo_q >= tmo_limit);
    // Ids below ID_BASE borrow into bit 8 and are rejected with the too-high ones.
    assign slot_wide   = {1'b0, id_q} - 9'(ID_BASE);
    assign in_range    = !slot_wide[8] && (slot_wide[7:0] < 8'(NUMBER_OF_MOTORS));
    assign crc_ok      = (rx_crc_q == crc_q);
    assign last_byte   = byte_valid && (idx_q == 4'(ARM_BUS_FRAME_LEN - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) fstate_q <= F_HUNT;
        else        fstate_q <= fstate_d;
    end

    always_comb begin
        fstate_d = fstate_q;
        good_ev  = 1'b0;
        crc_ev   = 1'b0;
        frm_ev   = 1'b0;
        case (fstate_q)
            F_HUNT: begin
                if (byte_valid && rx_byte == ARM_BUS_SOF) fstate_d = F_BODY;
            end
            F_BODY: begin
                if (byte_valid) begin
                    if (last_byte) fstate_d = F_CHECK;
                end else if (byte_err || tmo_expired) begin
                    frm_ev   = 1'b1;
                    fstate_d = F_HUNT;
                end
            end
            F_CHECK: begin
                good_ev  = crc_ok && in_range;
                crc_ev   = !crc_ok;
                fstate_d = F_HUNT;
            end
            default: fstate_d = F_HUNT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q      <= '0;
            crc_q      <= CRC16_INIT;
            rx_crc_q   <= '0;
            id_q       <= '0;
            enc0_q     <= '0;
            enc1_q     <= '0;
            cur_q      <= '0;
            err_q      <= '0;
            tmo_q      <= '0;
            valid_q    <= 1'b0;
            motor_q    <= '0;
            enc0_out_q <= '0;
            enc1_out_q <= '0;
            cur_out_q  <= '0;
            err_out_q  <= '0;
        end else begin
            valid_q <= good_ev;
            if (good_ev) begin
                motor_q    <= slot_wide[7:0];
                enc0_out_q <= enc0_q;
                enc1_out_q <= enc1_q;
                cur_out_q  <= cur_q;
                err_out_q  <= err_q;
            end
            case (fstate_q)
                F_HUNT: begin
                    if (byte_valid && rx_byte == ARM_BUS_SOF) begin
                        crc_q <= CRC16_INIT;
                        idx_q <= 4'd1;
                        tmo_q <= '0;
                    end
                end
                F_BODY: begin
                    if (byte_valid) begin
                        tmo_q <= '0;
                        idx_q <= idx_q + 4'd1;
                        // CRC covers id..err (indices 1..8); the trailing two bytes are the check value.
                        if (idx_q <= 4'd8) crc_q <= crc16_byte(crc_q, rx_byte);
                        case (idx_q)
                            4'd1:    id_q           <= rx_byte;
                            4'd2:    enc0_q[15:8]   <= rx_byte;
                            4'd3:    enc0_q[7:0]    <= rx_byte;
                            4'd4:    enc1_q[15:8]   <= rx_byte;
                            4'd5:    enc1_q[7:0]    <= rx_byte;
                            4'd6:    cur_q[15:8]    <= rx_byte;
                            4'd7:    cur_q[7:0]     <= rx_byte;
                            4'd8:    err_q          <= rx_byte;
                            4'd9:    rx_crc_q[15:8] <= rx_byte;
                            4'd10:   rx_crc_q[7:0]  <= rx_byte;
                            default: ;
                        endcase
                    end else begin
                        tmo_q <= tmo_q + 32'd1;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef ARM_BUS_RX_STATS_EN
    logic [31:0] good_q;
    logic [31:0] crc_err_q;
    logic [31:0] frm_err_q;

    // Saturating counters; independent enables so coincident events all count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            good_q    <= '0;
            crc_err_q <= '0;
            frm_err_q <= '0;
        end else begin
            if (good_ev && good_q != '1)    good_q    <= good_q + 32'd1;
            if (crc_ev && crc_err_q != '1)  crc_err_q <= crc_err_q + 32'd1;
            if (frm_ev && frm_err_q != '1)  frm_err_q <= frm_err_q + 32'd1;
        end
    end

    assign bus.good_frames    = good_q;
    assign bus.crc_errors     = crc_err_q;
    assign bus.framing_errors = frm_err_q;
`else
    logic stats_unused;
    assign stats_unused       = crc_ev ^ frm_ev;
    assign bus.good_frames    = '0;
    assign bus.crc_errors     = '0;
    assign bus.framing_errors = '0;
`endif

    assign bus.status_valid      = valid_q;
    assign bus.status_motor      = motor_q;
    assign bus.encoder0_position = enc0_out_q;
    assign bus.encoder1_position = enc1_out_q;
    assign bus.current           = cur_out_q;
    assign bus.error_code        = err_out_q;
    assign bus.frame_state       = fstate_q;
    assign bus.rx_state          = rx_state;
    assign bus.rx_busy           = rx_busy;

endmodule

// File: tb/tb_arm_bus_status_rx.sv
// Bench for arm_bus_status_rx: directed frames then randomized frames against a frame-level model.
module tb_arm_bus_status_rx;
    import arm_bus_pkg::*;

    localparam int ID_BASE_M = 128;
    localparam int N_M       = 10;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        rx_i;
    logic [15:0] clks_per_bit;

    always #5 clk = ~clk;

    arm_bus_status_rx_if bus();

    arm_bus_status_rx dut (
        .clk          (clk),
        .reset        (reset),
        .rx_i         (rx_i),
        .clks_per_bit (clks_per_bit),
        .bus          (bus)
    );

    // ---------------- scoreboard state ----------------
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [63:0] exp_q[$];
    logic [63:0] last_rec = '0;
    int          m_good = 0;
    int          m_crc  = 0;
    int          m_frm  = 0;
    int          bp     = 16;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] mk_rec(input logic [7:0] slot, input logic [15:0] e0,
                                           input logic [15:0] e1, input logic [15:0] cur,
                                           input logic [7:0] err);
        return {slot, e0, e1, cur, err};
    endfunction

    function automatic logic [63:0] obs_rec();
        return {bus.status_motor, bus.encoder0_position, bus.encoder1_position,
                bus.current, bus.error_code};
    endfunction

    function automatic logic [31:0] exp_cnt(input int v);
`ifdef ARM_BUS_RX_STATS_EN
        return 32'(v);
`else
        return 32'd0 & 32'(v);
`endif
    endfunction

    // Bit-serial LFSR form of CRC-16-CCITT over the eight payload bytes.
    function automatic logic [15:0] model_crc(input logic [7:0] m [8]);
        logic [15:0] c;
        logic        fb;
        c = 16'hFFFF;
        for (int i = 0; i < 8; i++) begin
            for (int b = 7; b >= 0; b--) begin
                fb = c[15] ^ m[i][b];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    // Strobe monitor: every status_valid must match the oldest expected record.
    always @(negedge clk) begin
        if (reset === 1'b1 && bus.status_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {63'd0, bus.status_valid}, 64'd0);
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                chk("status_fields", obs_rec(), e);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_cpb(input int v);
        clks_per_bit = 16'(v);
        bp = (v < 4) ? 4 : v;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        rx_i = 1'b0;
        repeat (bp) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (bp) @(posedge clk);
        end
        rx_i = stop;
        repeat (bp) @(posedge clk);
        rx_i = 1'b1;
        if (!stop) repeat (2 * bp) @(posedge clk);
        else       repeat (1) @(posedge clk);
    endtask

    task automatic settle_check(input string tag);
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk({tag, ":pending_strobes"}, 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        chk({tag, ":good_frames"},    64'(bus.good_frames),    64'(exp_cnt(m_good)));
        chk({tag, ":crc_errors"},     64'(bus.crc_errors),     64'(exp_cnt(m_crc)));
        chk({tag, ":framing_errors"}, 64'(bus.framing_errors), 64'(exp_cnt(m_frm)));
        chk({tag, ":held_fields"},    obs_rec(),               last_rec);
    endtask

    // bad_at: byte index sent with a 0 stop bit (rest of frame dropped), -1 for none.
    // n_bytes < 11 truncates the frame and then idles past the inter-byte timeout.
    task automatic send_frame(input logic [7:0] id, input logic [15:0] e0, input logic [15:0] e1,
                              input logic [15:0] cur, input logic [7:0] err,
                              input logic [7:0] crc_flip, input int bad_at, input int n_bytes,
                              input string tag);
        logic [7:0]  f [11];
        logic [7:0]  m [8];
        logic [15:0] c;
        logic [63:0] rec;
        bit          complete;
        bit          in_range;
        f[0] = ARM_BUS_SOF; f[1] = id;
        f[2] = e0[15:8];    f[3] = e0[7:0];
        f[4] = e1[15:8];    f[5] = e1[7:0];
        f[6] = cur[15:8];   f[7] = cur[7:0];
        f[8] = err;
        for (int i = 0; i < 8; i++) m[i] = f[i + 1];
        c = model_crc(m);
        f[9]  = c[15:8];
        f[10] = c[7:0] ^ crc_flip;

        complete = (n_bytes == 11) && !(bad_at >= 0 && bad_at < 11);
        in_range = (int'(id) >= ID_BASE_M) && (int'(id) - ID_BASE_M < N_M);
        if (complete) begin
            if (crc_flip == 8'h00 && in_range) begin
                rec = mk_rec(8'(int'(id) - ID_BASE_M), e0, e1, cur, err);
                exp_q.push_back(rec);
                last_rec = rec;
                m_good++;
            end
            if (crc_flip != 8'h00) m_crc++;
        end

        for (int i = 0; i < n_bytes; i++) begin
            if (i == bad_at) begin
                send_byte(f[i], 1'b0);
                break;
            end
            send_byte(f[i], 1'b1);
        end

        if (bad_at >= 1 && bad_at < n_bytes) begin
            m_frm++;
        end else if (n_bytes < 11) begin
            repeat (21 * bp + 10) @(posedge clk);
            if (n_bytes >= 1) m_frm++;
        end
        settle_check(tag);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, ":fields"},       obs_rec(),                   64'd0);
        chk({tag, ":status_valid"}, 64'(bus.status_valid),       64'd0);
        chk({tag, ":good_frames"},  64'(bus.good_frames),        64'd0);
        chk({tag, ":crc_errors"},   64'(bus.crc_errors),         64'd0);
        chk({tag, ":framing"},      64'(bus.framing_errors),     64'd0);
        chk({tag, ":frame_state"},  64'(bus.frame_state),        64'(F_HUNT));
        chk({tag, ":rx_state"},     64'(bus.rx_state),           64'(RX_IDLE));
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0]  r_id;
        logic [15:0] r_e0, r_e1, r_cur;
        logic [7:0]  r_err;
        int          kind;

        reset = 1'b0;
        rx_i  = 1'b1;
        set_cpb(16);
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset_state");
        reset = 1'b1;
        repeat (4) @(posedge clk);

        // Single good frame: slot 3, enc1 = -2.
        send_frame(8'h83, 16'h1234, 16'hFFFE, 16'h0100, 8'h00, 8'h00, -1, 11, "single_frame");
        chk("enc1_signed", 64'($signed(bus.encoder1_position)), 64'(-2));

        // CRC failure holds the previous outputs.
        send_frame(8'h83, 16'h5555, 16'h6666, 16'h7777, 8'h11, 8'h01, -1, 11, "bad_crc");

        // Bad stop on byte 5, then a good frame.
        send_frame(8'h84, 16'hAAAA, 16'h0001, 16'h0002, 8'h03, 8'h00, 5, 11, "bad_stop");
        send_frame(8'h85, 16'h8000, 16'h7FFF, 16'hFFFF, 8'hFF, 8'h00, -1, 11, "after_bad_stop");

        // Inter-byte timeout after 4 bytes, then a good frame.
        send_frame(8'h86, 16'h0102, 16'h0304, 16'h0506, 8'h07, 8'h00, -1, 4, "timeout");
        chk("timeout:frame_state", 64'(bus.frame_state), 64'(F_HUNT));
        send_frame(8'h87, 16'hAAAA, 16'hAA55, 16'h00AA, 8'hAA, 8'h00, -1, 11, "after_timeout");

        // Hunt garbage, out-of-range id, then slot 0.
        send_byte(8'h00, 1'b1);
        send_byte(8'h13, 1'b1);
        send_frame(8'h90, 16'h1111, 16'h2222, 16'h3333, 8'h44, 8'h00, -1, 11, "id_out_of_range");
        send_frame(8'h80, 16'h4321, 16'h8765, 16'h0FED, 8'h5A, 8'h00, -1, 11, "slot_zero");
        send_frame(8'h89, 16'h0F0F, 16'hF0F0, 16'h1000, 8'h09, 8'h00, -1, 11, "slot_top");
        send_frame(8'h7F, 16'h0F0F, 16'hF0F0, 16'h1000, 8'h09, 8'h00, -1, 11, "id_below_base");

        // Reset after six bytes of a frame.
        send_byte(ARM_BUS_SOF, 1'b1);
        send_byte(8'h82, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        send_byte(8'h56, 1'b1);
        send_byte(8'h78, 1'b1);
        reset = 1'b0;
        #1;
        check_all_zero("reset_mid_frame");
        m_good = 0; m_crc = 0; m_frm = 0; last_rec = '0; exp_q.delete();
        repeat (5) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (4) @(posedge clk);
        send_frame(8'h88, 16'hCAFE, 16'hBEEF, 16'h0042, 8'h01, 8'h00, -1, 11, "after_reset");

        // clks_per_bit below the floor behaves as 4.
        set_cpb(2);
        send_frame(8'h81, 16'h0A0B, 16'h0C0D, 16'h0E0F, 8'h10, 8'h00, -1, 11, "cpb_floor");

        // Randomized frames.
        for (int k = 0; k < 24; k++) begin
            set_cpb($urandom_range(1, 12));
            r_id  = 8'(ID_BASE_M + $urandom_range(0, N_M - 1));
            r_e0  = 16'($urandom);
            r_e1  = 16'($urandom);
            r_cur = 16'($urandom);
            r_err = 8'($urandom);
            kind  = $urandom_range(0, 9);
            case (kind)
                5: send_frame(r_id, r_e0, r_e1, r_cur, r_err, 8'($urandom_range(1, 255)), -1, 11, "rand_crc");
                6: send_frame(r_id, r_e0, r_e1, r_cur, r_err, 8'h00, $urandom_range(1, 10), 11, "rand_stop");
                7: send_frame(r_id, r_e0, r_e1, r_cur, r_err, 8'h00, -1, $urandom_range(1, 10), "rand_trunc");
                8: begin
                    r_id = 8'($urandom_range(0, 255));
                    if (int'(r_id) >= ID_BASE_M && int'(r_id) < ID_BASE_M + N_M) r_id = 8'h10;
                    send_frame(r_id, r_e0, r_e1, r_cur, r_err, 8'h00, -1, 11, "rand_range");
                end
                9: begin
                    for (int g = 0; g < $urandom_range(1, 3); g++) begin
                        logic [7:0] gb;
                        gb = 8'($urandom);
                        if (gb == ARM_BUS_SOF) gb = 8'h55;
                        send_byte(gb, 1'b1);
                    end
                    send_frame(r_id, r_e0, r_e1, r_cur, r_err, 8'h00, -1, 11, "rand_garbage");
                end
                default: send_frame(r_id, r_e0, r_e1, r_cur, r_err, 8'h00, -1, 11, "rand_good");
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
